// File: rtl/lap_recall_ctrl.sv
// Lap/recall controller: captures BCD lap times into a circular buffer and muxes the display source.
// Optional macro LAP_SPLIT_EN: RECALL shows split times (BCD difference to the previous lap).
module lap_recall_ctrl #(
  parameter int LAP_DEPTH  = 8,
  parameter int AW         = 3,
  parameter int HOLD_TICKS = 2000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          lap_btn,
  input  logic          mode_btn,
  input  logic          counting,
  input  logic          reset_timer,
  input  logic [15:0]   live_time,
  output logic [15:0]   disp_time,
  output logic [AW:0]   lap_count,
  output logic [AW-1:0] recall_idx,
  output logic [1:0]    state_o,
  output logic          overflow
);

  localparam logic [1:0] ST_LIVE   = 2'b00;
  localparam logic [1:0] ST_HOLD   = 2'b01;
  localparam logic [1:0] ST_RECALL = 2'b10;

  localparam int            HW          = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - 1);
  localparam logic [AW:0]   DEPTH_C     = (AW + 1)'(LAP_DEPTH);

  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_lap_count;
  logic [AW-1:0] r_recall_idx;
  logic          r_overflow;
  logic [HW-1:0] r_hold;
  logic          r_lap_q;
  logic          r_mode_q;
  logic [15:0]   r_disp;
  logic [15:0]   r_buf [LAP_DEPTH];

  logic          w_lap_press;
  logic          w_mode_press;
  logic          w_capture;
  logic [AW-1:0] w_count_lo;
  logic [AW-1:0] w_newest_phys;
  logic [AW-1:0] w_rec_phys;
  logic [15:0]   w_recall_val;

  // Press = released-to-pressed edge between consecutive clk_en samples.
  assign w_lap_press  = clk_en & r_lap_q  & ~lap_btn;
  assign w_mode_press = clk_en & r_mode_q & ~mode_btn;
  assign w_capture    = w_lap_press & ~w_mode_press & ~reset_timer & counting &
                        ((r_state == ST_LIVE) || (r_state == ST_HOLD));

  // A full buffer has lap_count == LAP_DEPTH, whose low bits wrap to 0 as intended.
  assign w_count_lo    = r_lap_count[AW-1:0];
  assign w_newest_phys = r_wr_ptr - 1'b1;
  assign w_rec_phys    = r_wr_ptr - w_count_lo + r_recall_idx;

`ifdef LAP_SPLIT_EN
  logic [AW-1:0] w_prev_phys;
  logic [15:0]   w_prev_val;

  function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  d;
    logic        borrow;
    logic [15:0] res;
    res    = '0;
    borrow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
      if (d[4]) begin
        d      = d + ((i == 3) ? 5'd6 : 5'd10);
        borrow = 1'b1;
      end else begin
        borrow = 1'b0;
      end
      res[4*i +: 4] = d[3:0];
    end
    return res;
  endfunction

  assign w_prev_phys  = w_rec_phys - 1'b1;
  assign w_prev_val   = (r_recall_idx == '0) ? 16'h0000 : r_buf[w_prev_phys];
  assign w_recall_val = bcd_sub(r_buf[w_rec_phys], w_prev_val);
`else
  assign w_recall_val = r_buf[w_rec_phys];
`endif

  // Buffer contents need no reset; lap_count defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf[r_wr_ptr] <= live_time;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_LIVE;
      r_wr_ptr     <= '0;
      r_lap_count  <= '0;
      r_recall_idx <= '0;
      r_overflow   <= 1'b0;
      r_hold       <= '0;
      r_lap_q      <= 1'b1;
      r_mode_q     <= 1'b1;
      r_disp       <= 16'h0000;
    end else begin
      if (clk_en) begin
        r_lap_q  <= lap_btn;
        r_mode_q <= mode_btn;
      end

      case (r_state)
        ST_LIVE:   r_disp <= live_time;
        ST_HOLD:   r_disp <= r_buf[w_newest_phys];
        ST_RECALL: r_disp <= w_recall_val;
        default: begin
          r_disp  <= live_time;
          r_state <= ST_LIVE;
        end
      endcase

      // Hold countdown is the default; later assignments (capture, mode) override it.
      if (clk_en && (r_state == ST_HOLD)) begin
        if (r_hold == '0) r_state <= ST_LIVE;
        else              r_hold  <= r_hold - 1'b1;
      end

      if (reset_timer) begin
        r_state      <= ST_LIVE;
        r_wr_ptr     <= '0;
        r_lap_count  <= '0;
        r_recall_idx <= '0;
        r_overflow   <= 1'b0;
        r_hold       <= '0;
      end else if (w_mode_press) begin
        if (r_state == ST_RECALL) begin
          r_state <= ST_LIVE;
        end else if (r_lap_count != '0) begin
          r_state      <= ST_RECALL;
          r_recall_idx <= w_count_lo - 1'b1;
        end
      end else if (w_lap_press) begin
        if (r_state == ST_RECALL) begin
          if (r_recall_idx == '0) r_recall_idx <= w_count_lo - 1'b1;
          else                    r_recall_idx <= r_recall_idx - 1'b1;
        end else if (w_capture) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_lap_count == DEPTH_C) r_overflow  <= 1'b1;
          else                        r_lap_count <= r_lap_count + 1'b1;
          r_hold  <= HOLD_RELOAD;
          r_state <= ST_HOLD;
        end
      end
    end
  end

  assign disp_time  = r_disp;
  assign lap_count  = r_lap_count;
  assign recall_idx = r_recall_idx;
  assign state_o    = r_state;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_lap_recall_ctrl.sv
// Directed bench for lap_recall_ctrl; expectations follow the LAP_SPLIT_EN build setting.
module tb_lap_recall_ctrl;

  localparam logic [1:0] ST_LIVE   = 2'b00;
  localparam logic [1:0] ST_HOLD   = 2'b01;
  localparam logic [1:0] ST_RECALL = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        lap_btn;
  logic        mode_btn;
  logic        counting;
  logic        reset_timer;
  logic [15:0] live_time;
  logic [15:0] disp_time;
  logic [3:0]  lap_count;
  logic [2:0]  recall_idx;
  logic [1:0]  state_o;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  lap_recall_ctrl #(.LAP_DEPTH(8), .AW(3), .HOLD_TICKS(2000)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .lap_btn(lap_btn), .mode_btn(mode_btn),
    .counting(counting), .reset_timer(reset_timer), .live_time(live_time),
    .disp_time(disp_time), .lap_count(lap_count), .recall_idx(recall_idx),
    .state_o(state_o), .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic press_lap();
    lap_btn = 1'b0; tick();
    lap_btn = 1'b1; tick();
  endtask

  task automatic press_mode();
    mode_btn = 1'b0; tick();
    mode_btn = 1'b1; tick();
  endtask

  task automatic press_both();
    lap_btn = 1'b0; mode_btn = 1'b0; tick();
    lap_btn = 1'b1; mode_btn = 1'b1; tick();
  endtask

  task automatic capture(input logic [15:0] t);
    live_time = t;
    counting  = 1'b1;
    press_lap();
  endtask

  task automatic test_reset();
    capture(16'h4321);
    rst = 1'b1; cyc(); rst = 1'b0;
    n_checks++; if (state_o !== ST_LIVE) begin n_fail++; $display("FAIL rst_state: got %b expected %b", state_o, ST_LIVE); end
    n_checks++; if (disp_time !== 16'h0000) begin n_fail++; $display("FAIL rst_disp: got %h expected 0000", disp_time); end
    n_checks++; if (lap_count !== 4'd0) begin n_fail++; $display("FAIL rst_lap_count: got %0d expected 0", lap_count); end
    n_checks++; if (recall_idx !== 3'd0) begin n_fail++; $display("FAIL rst_recall_idx: got %0d expected 0", recall_idx); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_capture_hold();
    apply_rst();
    live_time = 16'h1234; counting = 1'b1;
    lap_btn = 1'b0; tick();
    n_checks++; if (state_o !== ST_HOLD) begin n_fail++; $display("FAIL cap_state: got %b expected %b", state_o, ST_HOLD); end
    n_checks++; if (lap_count !== 4'd1) begin n_fail++; $display("FAIL cap_lap_count: got %0d expected 1", lap_count); end
    lap_btn = 1'b1; live_time = 16'h5678; tick();
    n_checks++; if (disp_time !== 16'h1234) begin n_fail++; $display("FAIL hold_disp: got %h expected 1234", disp_time); end
    repeat (1998) tick();
    n_checks++; if (state_o !== ST_HOLD) begin n_fail++; $display("FAIL hold_before_expiry: got %b expected %b", state_o, ST_HOLD); end
    tick();
    n_checks++; if (state_o !== ST_LIVE) begin n_fail++; $display("FAIL hold_expired: got %b expected %b", state_o, ST_LIVE); end
    cyc();
    n_checks++; if (disp_time !== 16'h5678) begin n_fail++; $display("FAIL live_track: got %h expected 5678", disp_time); end
  endtask

  task automatic test_overflow();
    logic [15:0] vals [9];
    logic [15:0] exp_v;
    vals = '{16'h0105, 16'h0210, 16'h0315, 16'h0420, 16'h0525,
             16'h0630, 16'h0735, 16'h0840, 16'h0945};
    apply_rst();
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(vals[k]);
      if (exp_q.size() > 8) void'(exp_q.pop_front());
      capture(vals[k]);
    end
    n_checks++; if (lap_count !== 4'd8) begin n_fail++; $display("FAIL ovf_lap_count: got %0d expected 8", lap_count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    press_mode();
    n_checks++; if (recall_idx !== 3'd7) begin n_fail++; $display("FAIL ovf_recall_idx: got %0d expected 7", recall_idx); end
`ifdef LAP_SPLIT_EN
    exp_v = 16'h0105;
`else
    exp_v = exp_q[7];
`endif
    n_checks++; if (disp_time !== exp_v) begin n_fail++; $display("FAIL ovf_newest: got %h expected %h", disp_time, exp_v); end
    for (int i = 6; i >= 0; i--) begin
      press_lap();
`ifdef LAP_SPLIT_EN
      exp_v = (i == 0) ? exp_q[0] : 16'h0105;
`else
      exp_v = exp_q[i];
`endif
      n_checks++; if (recall_idx !== 3'(i)) begin n_fail++; $display("FAIL ovf_walk_idx: got %0d expected %0d", recall_idx, i); end
      n_checks++; if (disp_time !== exp_v) begin n_fail++; $display("FAIL ovf_walk_disp idx %0d: got %h expected %h", i, disp_time, exp_v); end
    end
    reset_timer = 1'b1; cyc(); reset_timer = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_recall();
    logic [15:0] exp_d [4];
    logic [2:0]  exp_i [4];
`ifdef LAP_SPLIT_EN
    exp_d = '{16'h0750, 16'h0750, 16'h0500, 16'h0750};
`else
    exp_d = '{16'h2000, 16'h1250, 16'h0500, 16'h2000};
`endif
    exp_i = '{3'd2, 3'd1, 3'd0, 3'd2};
    apply_rst();
    capture(16'h0500); capture(16'h1250); capture(16'h2000);
    press_mode();
    n_checks++; if (state_o !== ST_RECALL) begin n_fail++; $display("FAIL recall_enter: got %b expected %b", state_o, ST_RECALL); end
    for (int s = 0; s < 4; s++) begin
      if (s > 0) press_lap();
      n_checks++; if (recall_idx !== exp_i[s]) begin n_fail++; $display("FAIL recall_idx step %0d: got %0d expected %0d", s, recall_idx, exp_i[s]); end
      n_checks++; if (disp_time !== exp_d[s]) begin n_fail++; $display("FAIL recall_disp step %0d: got %h expected %h", s, disp_time, exp_d[s]); end
    end
    n_checks++; if (lap_count !== 4'd3) begin n_fail++; $display("FAIL recall_no_capture: got %0d expected 3", lap_count); end
    press_mode();
    n_checks++; if (state_o !== ST_LIVE) begin n_fail++; $display("FAIL recall_exit: got %b expected %b", state_o, ST_LIVE); end
  endtask

  task automatic test_same_sample();
    int budget;
    apply_rst();
    capture(16'h0100); capture(16'h0200);
    budget = 0;
    while (state_o !== ST_LIVE && budget < 2100) begin
      tick();
      budget++;
    end
    n_checks++; if (state_o !== ST_LIVE) begin n_fail++; $display("FAIL same_wait_live: got %b expected %b", state_o, ST_LIVE); end
    live_time = 16'h0300;
    press_both();
    n_checks++; if (state_o !== ST_RECALL) begin n_fail++; $display("FAIL same_state: got %b expected %b", state_o, ST_RECALL); end
    n_checks++; if (lap_count !== 4'd2) begin n_fail++; $display("FAIL same_lap_count: got %0d expected 2", lap_count); end
    n_checks++; if (recall_idx !== 3'd1) begin n_fail++; $display("FAIL same_idx: got %0d expected 1", recall_idx); end
`ifdef LAP_SPLIT_EN
    n_checks++; if (disp_time !== 16'h0100) begin n_fail++; $display("FAIL same_disp: got %h expected 0100", disp_time); end
`else
    n_checks++; if (disp_time !== 16'h0200) begin n_fail++; $display("FAIL same_disp: got %h expected 0200", disp_time); end
`endif
  endtask

  task automatic test_reset_timer();
    apply_rst();
    for (int k = 1; k <= 5; k++) capture(16'(k * 256));
    press_mode();
    n_checks++; if (state_o !== ST_RECALL) begin n_fail++; $display("FAIL rt_recall: got %b expected %b", state_o, ST_RECALL); end
    n_checks++; if (lap_count !== 4'd5) begin n_fail++; $display("FAIL rt_count5: got %0d expected 5", lap_count); end
    reset_timer = 1'b1; cyc(); reset_timer = 1'b0;
    n_checks++; if (state_o !== ST_LIVE) begin n_fail++; $display("FAIL rt_state: got %b expected %b", state_o, ST_LIVE); end
    n_checks++; if (lap_count !== 4'd0) begin n_fail++; $display("FAIL rt_lap_count: got %0d expected 0", lap_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rt_overflow: got %b expected 0", overflow); end
    n_checks++; if (recall_idx !== 3'd0) begin n_fail++; $display("FAIL rt_idx: got %0d expected 0", recall_idx); end
    press_mode();
    n_checks++; if (state_o !== ST_LIVE) begin n_fail++; $display("FAIL rt_mode_ignored: got %b expected %b", state_o, ST_LIVE); end
  endtask

  task automatic test_not_counting_and_held();
    apply_rst();
    counting = 1'b0; live_time = 16'h0777;
    press_lap();
    n_checks++; if (lap_count !== 4'd0) begin n_fail++; $display("FAIL nc_lap_count: got %0d expected 0", lap_count); end
    n_checks++; if (state_o !== ST_LIVE) begin n_fail++; $display("FAIL nc_state: got %b expected %b", state_o, ST_LIVE); end
    n_checks++; if (disp_time !== 16'h0777) begin n_fail++; $display("FAIL nc_disp: got %h expected 0777", disp_time); end
    counting = 1'b1;
    lap_btn = 1'b0;
    repeat (50) tick();
    lap_btn = 1'b1; tick();
    n_checks++; if (lap_count !== 4'd1) begin n_fail++; $display("FAIL held_one_event: got %0d expected 1", lap_count); end
    n_checks++; if (state_o !== ST_HOLD) begin n_fail++; $display("FAIL held_state: got %b expected %b", state_o, ST_HOLD); end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; lap_btn = 1'b1; mode_btn = 1'b1;
    counting = 1'b0; reset_timer = 1'b0; live_time = 16'h0000;
    cyc(); cyc();
    rst = 1'b0;
    test_reset();
    test_capture_hold();
    test_overflow();
    test_recall();
    test_same_sample();
    test_reset_timer();
    test_not_counting_and_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lap_recall_ctrl.md
Name: lap_recall_ctrl

Overview:
Lap/recall controller sitting between the time counter and the 7-segment driver.
- Captures the live BCD time into a circular lap buffer on a debounced LAP press, and freezes the display on that lap for a hold period.
- On MODE press, switches the display source to stored laps and steps through them.
- Owns the display-source mux; the seg7 driver digits come from disp_time instead of directly from the counter.

Parameters:
LAP_DEPTH, 8, lap buffer entries; power of 2, minimum 2
AW, 3, log2(LAP_DEPTH)
HOLD_TICKS, 2000, clk_en ticks the display freezes after a capture (2 s at 1 kHz)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high
clk_en  in  1  ~1 kHz display/debounce enable pulse, one clk wide
lap_btn  in  1  debounced LAP button, active-low level
mode_btn  in  1  debounced MODE button, active-low level
counting  in  1  stopwatch FSM counting flag
reset_timer  in  1  stopwatch FSM timer-clear request
live_time  in  16  {sec_tens, sec_ones, ms_hundreds, ms_tens} BCD
disp_time  out  16  BCD digits to the seg7 driver, same packing as live_time
lap_count  out  AW+1  number of valid laps, 0..LAP_DEPTH
recall_idx  out  AW  logical index shown in RECALL; 0 = oldest
state_o  out  2  LIVE=00, HOLD=01, RECALL=10
overflow  out  1  sticky: at least one lap overwritten

Behaviour:
- Reset (rst=1 at posedge clk) sets:
  - state LIVE
  - disp_time 16'h0000, lap_count 0, recall_idx 0, overflow 0
  - write pointer 0, hold counter 0, button history registers 1 (released)
  - Buffer contents are don't-care.
- Button sampling:
  - Buttons are sampled only on clk_en=1 cycles.
  - A press is a 1->0 transition between consecutive clk_en samples.
  - A press produces exactly one event; holding the button produces nothing further.
- Priority within one clk_en cycle: reset_timer > mode press > lap press. A lap press in the same sample as a mode press is dropped.
- reset_timer=1 on any clk cycle, regardless of clk_en:
  - lap_count, write pointer, recall_idx, overflow and hold counter go to 0; state goes to LIVE on the next edge.
- State LIVE: disp_time <= live_time every clk (1-cycle registered latency).
  - Lap press with counting=1:
    - Write live_time at wr_ptr; wr_ptr <= wr_ptr+1 (mod LAP_DEPTH).
    - lap_count <= min(lap_count+1, LAP_DEPTH).
    - If lap_count was already LAP_DEPTH, the oldest entry is overwritten and overflow <= 1.
    - hold <= HOLD_TICKS-1; state <= HOLD.
  - Lap press with counting=0: ignored.
  - Mode press with lap_count>0: state <= RECALL, recall_idx <= lap_count-1 (newest).
  - Mode press with lap_count=0: ignored.
- State HOLD: disp_time <= most recently captured entry.
  - On each clk_en: if hold==0, state <= LIVE; else hold decrements.
  - Lap press with counting=1: captures again (same rules as LIVE) and reloads hold.
  - Lap press with counting=0: ignored.
  - Mode press: same as LIVE.
- State RECALL: disp_time <= buffer[(wr_ptr - lap_count + recall_idx) mod LAP_DEPTH].
  - Lap press: recall_idx decrements, wrapping from 0 to lap_count-1. No capture, even if counting=1.
  - Mode press: state <= LIVE.
  - Counting continues unaffected in the time counter.
- Timing of writes and reads:
  - A buffer write and the state change take effect on the clk edge ending the clk_en cycle.
  - disp_time reflects the new source one clk later.
- Buffer is register-based; reads are combinational into the registered disp_time.

Optional Feature:
Macro: LAP_SPLIT_EN.
- Defined: RECALL shows the split time, computed as entry[recall_idx] - entry[recall_idx-1].
  - For recall_idx=0, the split is entry[0] - 00.00.
  - Subtraction is BCD with borrow chaining; radices are 10 for ms_tens, 10 for ms_hundreds, 10 for sec_ones, and 6 for sec_tens.
  - Result is always non-negative because laps are monotonic between timer resets.
  - HOLD still shows the absolute time.
- Not defined: RECALL shows absolute lap times; no subtractor is synthesised.

Test Plan:
- live_time=16'h1234, counting=1, lap press -> next clk buffer[0]=1234, lap_count=1, state HOLD, disp_time=1234. After 2000 clk_en ticks state LIVE and disp_time tracks live_time.
- 9 lap presses with live_time 0105,0210,...,0945 (+0105 each) -> lap_count=8, overflow=1, oldest surviving entry=0210.
- Three laps 0500,1250,2000; mode press -> RECALL, recall_idx=2, disp=2000. Lap presses -> idx 1 (1250), 0 (0500), 2 (2000 wrap). With LAP_SPLIT_EN the same sequence shows 0750, 0750, 0500, 0750.
- Mode press and lap press in the same clk_en sample from LIVE with lap_count=2 -> RECALL entered, no capture, lap_count stays 2.
- reset_timer pulse while in RECALL with lap_count=5 -> next clk: state LIVE, lap_count=0, overflow=0. A subsequent mode press is ignored.
- counting=0, lap press in LIVE -> no write, lap_count unchanged, state stays LIVE. Lap held low across 50 clk_en ticks -> at most one event.
